mag_cmp_serial: RTL and testbench



---
 rtl/mag_cmp_pkg.sv | 29 ++
 rtl/mag_cmp_serial_cmp2_cell.sv | 14 +
 rtl/mag_cmp_serial.sv | 129 ++++++++++++
 tb/tb_mag_cmp_serial.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mag_cmp_pkg.sv
// Shared types for the serial magnitude comparator: relation and FSM state
// encodings plus the one-hot result decoder.
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Returns {gt, eq, lt}; the unused encoding yields no flag at all.
    function automatic logic [2:0] rel_decode(input rel_t rel);
        logic [2:0] flags;
        case (rel)
            REL_GT:  flags = 3'b100;
            REL_EQ:  flags = 3'b010;
            REL_LT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/mag_cmp_serial_cmp2_cell.sv
// Purely combinational 2-bit magnitude compare cell (gt/eq/lt of a vs b).
module cmp2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
    assign lt = (b[1] & ~a[1]) | (~(a[1] ^ b[1]) & b[0] & ~a[0]);
    assign eq = ~(a[1] ^ b[1]) & ~(a[0] ^ b[0]);

endmodule

// File: rtl/mag_cmp_serial.sv
// Serial WIDTH-bit magnitude comparator consuming MSB-first 2-bit digit pairs.
// Define MAG_CMP_SIGNED_EN for a two's-complement compare (top digit sign flip).
module mag_cmp_serial
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dig_valid,
    output logic       dig_ready,
    input  logic [1:0] a_dig,
    input  logic [1:0] b_dig,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       a_gt_b,
    output logic       a_eq_b,
    output logic       a_lt_b,
    output logic       busy
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rel_t             rel_q, rel_d;

    logic [1:0] cell_a_s, cell_b_s;
    logic       cell_gt_s, cell_eq_s, cell_lt_s;
    rel_t       cell_rel_s;
    logic       accept_s;
    logic [2:0] flags_s;

`ifdef MAG_CMP_SIGNED_EN
    // The sign bit lives in the MSB of the first digit; flipping it maps
    // two's-complement order onto unsigned order.
    assign cell_a_s = (cnt_q == '0) ? {~a_dig[1], a_dig[0]} : a_dig;
    assign cell_b_s = (cnt_q == '0) ? {~b_dig[1], b_dig[0]} : b_dig;
`else
    assign cell_a_s = a_dig;
    assign cell_b_s = b_dig;
`endif

    cmp2_cell u_cell (
        .a  (cell_a_s),
        .b  (cell_b_s),
        .gt (cell_gt_s),
        .eq (cell_eq_s),
        .lt (cell_lt_s)
    );

    assign cell_rel_s = cell_gt_s ? REL_GT : (cell_lt_s ? REL_LT : REL_EQ);
    assign accept_s   = (state_q == S_RUN) && dig_valid;

    // Next-state, digit counter and running relation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rel_d   = REL_EQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept_s) begin
                    // The first unequal digit decides; later digits cannot override it.
                    if (rel_q == REL_EQ) begin
                        rel_d = cell_rel_s;
                    end else begin
                        rel_d = rel_q;
                    end
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rel_d   = REL_EQ;
            end
        endcase
    end

    // State, counter and relation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rel_q   <= REL_EQ;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

    // Outputs depend only on registered state, never on inputs.
    assign dig_ready = (state_q == S_RUN);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign flags_s   = res_valid ? rel_decode(rel_q) : 3'b000;
    assign a_gt_b    = flags_s[2];
    assign a_eq_b    = flags_s[1];
    assign a_lt_b    = flags_s[0];

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Directed self-checking bench: WIDTH=8 instance plus a WIDTH=2 instance.
module tb_mag_cmp_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0, dig_valid = 1'b0, res_ready = 1'b0;
    logic [1:0] a_dig = 2'b00, b_dig = 2'b00;
    logic       dig_ready, res_valid, a_gt_b, a_eq_b, a_lt_b, busy;

    logic       start2 = 1'b0, dig_valid2 = 1'b0, res_ready2 = 1'b0;
    logic [1:0] a_dig2 = 2'b00, b_dig2 = 2'b00;
    logic       dig_ready2, res_valid2, a_gt_b2, a_eq_b2, a_lt_b2, busy2;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

`ifdef MAG_CMP_SIGNED_EN
    localparam logic [2:0] EXP_80_7F = LT;
    localparam logic [2:0] EXP_03_C0 = GT;
`else
    localparam logic [2:0] EXP_80_7F = GT;
    localparam logic [2:0] EXP_03_C0 = LT;
`endif

    wire [2:0] flags  = {a_gt_b, a_eq_b, a_lt_b};
    wire [2:0] flags2 = {a_gt_b2, a_eq_b2, a_lt_b2};

    mag_cmp_serial #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dig_valid(dig_valid),
        .dig_ready(dig_ready), .a_dig(a_dig), .b_dig(b_dig),
        .res_valid(res_valid), .res_ready(res_ready),
        .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .busy(busy)
    );

    mag_cmp_serial #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .dig_valid(dig_valid2),
        .dig_ready(dig_ready2), .a_dig(a_dig2), .b_dig(b_dig2),
        .res_valid(res_valid2), .res_ready(res_ready2),
        .a_gt_b(a_gt_b2), .a_eq_b(a_eq_b2), .a_lt_b(a_lt_b2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start plus beats [0..nbeats-1] back to back; early flags any res_valid before the last beat.
    task automatic drive_beats(input logic [7:0] a, input logic [7:0] b,
                               input int nbeats, output logic early);
        early = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            dig_valid = 1'b1;
            a_dig = a[7-2*i -: 2];
            b_dig = b[7-2*i -: 2];
            tick();
            if (i < 3) early = early | res_valid;
        end
        dig_valid = 1'b0;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if ({dig_ready, res_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000", {dig_ready, res_valid, busy}); end
        n_cmp++; if (flags !== NONE) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", flags); end
        n_cmp++; if ({dig_ready2, res_valid2, busy2, flags2} !== 6'b0) begin n_fail++; $display("FAIL reset_w2: got %b expected 000000", {dig_ready2, res_valid2, busy2, flags2}); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({dig_ready, res_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL idle_ctl: got %b expected 000", {dig_ready, res_valid, busy}); end
    endtask

    task automatic test_first_digit_wins();
        logic early;
        drive_beats(8'h9C, 8'h9A, 4, early);
        n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL gt_early_valid: got %b expected 0", early); end
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL gt_res_valid: got %b expected 1", res_valid); end
        n_cmp++; if (flags !== GT) begin n_fail++; $display("FAIL gt_flags: got %b expected %b", flags, GT); end
        n_cmp++; if ({dig_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL gt_done_ctl: got %b expected 01", {dig_ready, busy}); end
        release_result();
        n_cmp++; if ({res_valid, busy, flags} !== 5'b0) begin n_fail++; $display("FAIL gt_release: got %b expected 00000", {res_valid, busy, flags}); end
    endtask

    task automatic test_bubbles();
        logic [7:0] v;
        v = 8'h5A;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if ({dig_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL bub_run_ctl: got %b expected 11", {dig_ready, busy}); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                dig_valid = 1'b0;
                a_dig = 2'b11;
                b_dig = 2'b00;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    n_cmp++; if ({dig_ready, res_valid} !== 2'b10) begin n_fail++; $display("FAIL bub_gap_ctl: got %b expected 10", {dig_ready, res_valid}); end
                end
            end
            dig_valid = 1'b1;
            a_dig = v[7-2*i -: 2];
            b_dig = v[7-2*i -: 2];
            tick();
            if (i < 3) begin
                n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bub_early_valid beat %0d: got %b expected 0", i, res_valid); end
            end
        end
        dig_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bub_res_valid: got %b expected 1", res_valid); end
        n_cmp++; if (flags !== EQ) begin n_fail++; $display("FAIL bub_flags: got %b expected %b", flags, EQ); end
        release_result();
    endtask

    task automatic test_sign_boundary();
        logic early;
        drive_beats(8'h80, 8'h7F, 4, early);
        n_cmp++; if ({res_valid, flags} !== {1'b1, EXP_80_7F}) begin n_fail++; $display("FAIL sign_80_7f: got %b expected %b", {res_valid, flags}, {1'b1, EXP_80_7F}); end
        release_result();
        drive_beats(8'h7F, 8'h80, 4, early);
        n_cmp++; if (flags !== {EXP_80_7F[0], 1'b0, EXP_80_7F[2]}) begin n_fail++; $display("FAIL sign_7f_80: got %b expected %b", flags, {EXP_80_7F[0], 1'b0, EXP_80_7F[2]}); end
        release_result();
    endtask

    task automatic test_hold_and_ignore_start();
        logic early;
        drive_beats(8'h12, 8'h34, 4, early);
        for (int c = 0; c < 5; c++) begin
            start = (c == 1 || c == 3);
            tick();
            n_cmp++; if ({res_valid, flags} !== {1'b1, LT}) begin n_fail++; $display("FAIL hold_cycle %0d: got %b expected 1001", c, {res_valid, flags}); end
        end
        start = 1'b1;
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        res_ready = 1'b0;
        n_cmp++; if ({res_valid, busy, flags} !== 5'b0) begin n_fail++; $display("FAIL hold_release: got %b expected 00000", {res_valid, busy, flags}); end
        tick();
        n_cmp++; if ({dig_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL hs_start_ignored: got %b expected 00", {dig_ready, busy}); end
    endtask

    task automatic test_async_reset();
        logic early;
        drive_beats(8'h03, 8'hC0, 2, early);
        n_cmp++; if ({dig_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL ar_midrun: got %b expected 11", {dig_ready, busy}); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({dig_ready, res_valid, busy, flags} !== 6'b0) begin n_fail++; $display("FAIL ar_immediate: got %b expected 000000", {dig_ready, res_valid, busy, flags}); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if ({dig_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL ar_idle: got %b expected 00", {dig_ready, busy}); end
        drive_beats(8'h03, 8'hC0, 4, early);
        n_cmp++; if ({res_valid, flags} !== {1'b1, EXP_03_C0}) begin n_fail++; $display("FAIL ar_fresh: got %b expected %b", {res_valid, flags}, {1'b1, EXP_03_C0}); end
        release_result();
    endtask

    task automatic test_width2();
        start2 = 1'b1;
        dig_valid2 = 1'b1;
        a_dig2 = 2'b11;
        b_dig2 = 2'b00;
        tick();
        start2 = 1'b0;
        n_cmp++; if ({dig_ready2, res_valid2, busy2} !== 3'b101) begin n_fail++; $display("FAIL w2_start_cycle: got %b expected 101", {dig_ready2, res_valid2, busy2}); end
        a_dig2 = 2'b01;
        b_dig2 = 2'b01;
        tick();
        dig_valid2 = 1'b0;
        n_cmp++; if ({res_valid2, flags2} !== {1'b1, EQ}) begin n_fail++; $display("FAIL w2_result: got %b expected 1010", {res_valid2, flags2}); end
        n_cmp++; if (dig_ready2 !== 1'b0) begin n_fail++; $display("FAIL w2_done_ready: got %b expected 0", dig_ready2); end
        res_ready2 = 1'b1;
        tick();
        res_ready2 = 1'b0;
        n_cmp++; if ({res_valid2, busy2, flags2} !== 5'b0) begin n_fail++; $display("FAIL w2_release: got %b expected 00000", {res_valid2, busy2, flags2}); end
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        dig_valid2 = 1'b1;
        a_dig2 = 2'b10;
        b_dig2 = 2'b11;
        tick();
        dig_valid2 = 1'b0;
        n_cmp++; if ({res_valid2, flags2} !== {1'b1, LT}) begin n_fail++; $display("FAIL w2_lt: got %b expected 1001", {res_valid2, flags2}); end
        res_ready2 = 1'b1;
        tick();
        res_ready2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_digit_wins();
        test_bubbles();
        test_sign_boundary();
        test_hold_and_ignore_start();
        test_async_reset();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
